// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding,
// baud-code constants, divisor table and the latched frame record.
package uart_pkg;

    // Scheduler FSM encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LAUNCH    = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;

    // Baud codes understood by the transmitter
    localparam logic [2:0] BC_434 = 3'd0;
    localparam logic [2:0] BC_217 = 3'd1;
    localparam logic [2:0] BC_109 = 3'd2;
    localparam logic [2:0] BC_72  = 3'd3;
    localparam logic [2:0] BC_36  = 3'd4;

    // Byte plus baud code as handed to the transmitter
    typedef struct packed {
        logic [7:0] data;
        logic [2:0] bc;
    } frame_t;

    // Codes above the table fall back to the slowest rate
    function automatic logic [2:0] bc_clean(input logic [2:0] bc);
        return (bc > BC_36) ? BC_434 : bc;
    endfunction

    // clk cycles per bit for each baud code
    function automatic logic [8:0] bc_div(input logic [2:0] bc);
        case (bc_clean(bc))
            BC_217:  return 9'd217;
            BC_109:  return 9'd109;
            BC_72:   return 9'd72;
            BC_36:   return 9'd36;
            default: return 9'd434;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after the last grant.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            vld
);

    // Walk from last+1 around the ring, stop at the first requester
    always_comb begin
        logic [IW-1:0] k;
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        k   = '0;
        for (int off = 1; off <= NREQ; off++) begin
            k = IW'((int'(last) + off) % NREQ);
            if (!vld && req[k]) begin
                vld    = 1'b1;
                idx    = k;
                gnt[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NREQ requesters: round-robin grant,
// one-cycle launch, busy handshake with timeout, enforced inter-frame gap.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int GAP_CYC = 16,
    parameter  int TMO_CYC = 64,
    localparam int IW      = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data_i,
    input  logic [3*NREQ-1:0] bc_i,
    output logic [NREQ-1:0]   ack,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [2:0]        tx_bc,
    input  logic              tx_busy,
    output logic [IW-1:0]     gnt_id,
    output logic              err_tmo
);

    localparam int CMAX = (TMO_CYC > GAP_CYC) ? TMO_CYC : GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    logic [2:0]             state;
    logic [CW-1:0]          cnt;
    frame_t                 frm;
    logic [NREQ-1:0]        gnt_oh;
    logic [NREQ-1:0][7:0]   data_v;
    logic [NREQ-1:0][2:0]   bc_v;
    logic [NREQ-1:0]        arb_gnt;
    logic [IW-1:0]          arb_idx;
    logic                   arb_vld;

    assign data_v  = data_i;
    assign bc_v    = bc_i;
    assign tx_data = frm.data;
    assign tx_bc   = frm.bc;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req  (req),
        .last (gnt_id),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .vld  (arb_vld)
    );

    // Launch only while the granted requester still asks; a withdrawn
    // request gets neither ack nor frame. ack is tx_start steered by grant.
    always_comb begin
        tx_start = (state == ST_LAUNCH) && |(req & gnt_oh);
        ack      = tx_start ? gnt_oh : '0;
    end

    // Scheduler FSM; cnt counts cycles since tx_start in WAIT_BUSY and
    // gap cycles in GAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            frm     <= '0;
            gnt_id  <= IW'(NREQ - 1);
            gnt_oh  <= '0;
            err_tmo <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        frm.data <= data_v[arb_idx];
                        frm.bc   <= bc_clean(bc_v[arb_idx]);
                        gnt_id   <= arb_idx;
                        gnt_oh   <= arb_gnt;
                        state    <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    cnt   <= CW'(1);
                    state <= tx_start ? ST_WAIT_BUSY : ST_IDLE;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        cnt   <= '0;
                        state <= ST_WAIT_DONE;
                    end else if (cnt >= CW'(TMO_CYC - 1)) begin
                        err_tmo <= 1'b1;
                        cnt     <= '0;
                        state   <= ST_GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        cnt   <= '0;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (GAP_CYC == 0 || cnt >= CW'(GAP_CYC - 1)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a simple transmitter busy model.
module tb_uart_tx_scheduler;

    localparam int NREQ  = 4;
    localparam int GAP   = 16;
    localparam int TMO   = 64;
    localparam int FRAME = 10;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ-1:0][7:0] dv = '0;
    logic [NREQ-1:0][2:0] bv = '0;
    logic [NREQ-1:0]      ack;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic [2:0]           tx_bc;
    logic                 tx_busy = 1'b0;
    logic [1:0]           gnt_id;
    logic                 err_tmo;

    typedef struct {
        int         cyc;
        logic [1:0] gid;
        logic [3:0] ack;
        logic [7:0] d;
        logic [2:0] bc;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  err_cyc = -1;
    int  nchk = 0;
    int  npass = 0;
    bit  model_en = 1'b1;

    uart_tx_scheduler #(.NREQ(NREQ), .GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .data_i   (dv),
        .bc_i     (bv),
        .ack      (ack),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_bc    (tx_bc),
        .tx_busy  (tx_busy),
        .gnt_id   (gnt_id),
        .err_tmo  (err_tmo)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs === exp) npass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Launch log and err_tmo rise time
    initial begin
        ev_t e;
        logic err_q;
        err_q = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                e.cyc = cyc; e.gid = gnt_id; e.ack = ack; e.d = tx_data; e.bc = tx_bc;
                q.push_back(e);
            end
            if (err_tmo && !err_q) err_cyc = cyc;
            err_q = err_tmo;
        end
    end

    // Transmitter model: busy 2 cycles after launch, for FRAME cycles
    initial forever begin
        @(negedge clk);
        if (tx_start && model_en) begin
            repeat (2) @(negedge clk);
            tx_busy = 1'b1;
            repeat (FRAME) @(negedge clk);
            tx_busy = 1'b0;
        end
    end

    task automatic wait_ev(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, q.size(), n);
    endtask

    task automatic chk_ev(input string tag, input int i, input logic [1:0] gid,
                          input logic [3:0] a, input logic [7:0] d, input logic [2:0] bc);
        if (i >= q.size()) chk({tag, "_missing"}, 0, 1);
        else begin
            chk({tag, "_gid"}, q[i].gid, gid);
            chk({tag, "_ack"}, q[i].ack, a);
            chk({tag, "_data"}, q[i].d, d);
            chk({tag, "_bc"}, q[i].bc, bc);
        end
    endtask

    task automatic wait_busy(input int budget);
        int k;
        k = 0;
        while (!tx_busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("busy_seen", tx_busy, 1);
    endtask

    task automatic set_req_next(input logic [3:0] r);
        @(posedge clk);
        #1 req = r;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int t0;
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_bc", tx_bc, 0);
        chk("rst_gnt", gnt_id, 3);
        chk("rst_err", err_tmo, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, two-cycle latency
        @(posedge clk);
        #1;
        dv[0] = 8'h0B; bv[0] = 3'd3; req = 4'b0001;
        chk("t1_start_c0", tx_start, 0);
        @(posedge clk);
        #1;
        chk("t1_start_c1", tx_start, 1);
        chk("t1_ack", ack, 4'b0001);
        chk("t1_data", tx_data, 8'h0B);
        chk("t1_bc", tx_bc, 3);
        chk("t1_gnt", gnt_id, 0);
        set_req_next(4'b0000);
        chk("t1_start_c2", tx_start, 0);
        repeat (50) @(posedge clk);

        // All four requesting continuously: round robin, fixed spacing
        do_reset();
        q.delete();
        dv = {8'h44, 8'h33, 8'h22, 8'h11};
        bv = {3'd4, 3'd6, 3'd1, 3'd2};
        @(posedge clk);
        #1 req = 4'b1111;
        wait_ev("t2_cnt", 5, 400);
        set_req_next(4'b0000);
        chk_ev("t2_e0", 0, 2'd0, 4'b0001, 8'h11, 3'd2);
        chk_ev("t2_e1", 1, 2'd1, 4'b0010, 8'h22, 3'd1);
        chk_ev("t2_e2", 2, 2'd2, 4'b0100, 8'h33, 3'd0);
        chk_ev("t2_e3", 3, 2'd3, 4'b1000, 8'h44, 3'd4);
        chk_ev("t2_e4", 4, 2'd0, 4'b0001, 8'h11, 3'd2);
        for (int i = 1; i < 5; i++)
            if (i < q.size()) chk("t2_spacing", q[i].cyc - q[i-1].cyc, FRAME + GAP + 4);
        repeat (60) @(posedge clk);

        // Timeout: no busy, err_tmo after TMO cycles, next requester after gap
        model_en = 1'b0;
        q.delete();
        err_cyc = -1;
        @(posedge clk);
        #1 req = 4'b0110;
        wait_ev("t3_cnt1", 1, 20);
        set_req_next(4'b0100);
        wait_ev("t3_cnt2", 2, 300);
        set_req_next(4'b0000);
        chk_ev("t3_e0", 0, 2'd1, 4'b0010, 8'h22, 3'd1);
        chk_ev("t3_e1", 1, 2'd2, 4'b0100, 8'h33, 3'd0);
        if (q.size() >= 2) begin
            chk("t3_err_time", err_cyc - q[0].cyc, TMO);
            chk("t3_relaunch", q[1].cyc - q[0].cyc, TMO + GAP + 1);
        end
        chk("t3_err_sticky", err_tmo, 1);
        repeat (100) @(posedge clk);

        // Reset during WAIT_DONE
        model_en = 1'b1;
        do_reset();
        q.delete();
        dv[0] = 8'h5A; bv[0] = 3'd4;
        @(posedge clk);
        #1 req = 4'b0001;
        wait_ev("t4_cnt1", 1, 20);
        set_req_next(4'b0000);
        wait_busy(20);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_rst_start", tx_start, 0);
        chk("t4_rst_ack", ack, 0);
        chk("t4_rst_data", tx_data, 0);
        chk("t4_rst_bc", tx_bc, 0);
        chk("t4_rst_gnt", gnt_id, 3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        t0 = 0;
        while (tx_busy && t0 < 30) begin
            @(negedge clk);
            t0++;
        end
        @(posedge clk);
        #1;
        dv[2] = 8'h77; bv[2] = 3'd1; req = 4'b0100;
        t0 = cyc;
        wait_ev("t4_cnt2", 1, 20);
        set_req_next(4'b0000);
        chk_ev("t4_e0", 0, 2'd2, 4'b0100, 8'h77, 3'd1);
        if (q.size() >= 1) chk("t4_latency", q[0].cyc - t0, 1);
        repeat (50) @(posedge clk);

        // Request raised and withdrawn while another frame is in flight
        q.delete();
        @(posedge clk);
        #1 req = 4'b0001;
        wait_ev("t5_cnt1", 1, 20);
        set_req_next(4'b0000);
        wait_busy(20);
        set_req_next(4'b0010);
        repeat (3) @(posedge clk);
        #1 req = 4'b0000;
        repeat (60) @(posedge clk);
        chk("t5_cnt", q.size(), 1);
        chk_ev("t5_e0", 0, 2'd0, 4'b0001, 8'h5A, 3'd4);
        chk("t5_data_hold", tx_data, 8'h5A);
        chk("t5_gnt_hold", gnt_id, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
